// File: rtl/shift_pkg.sv
// Shared types and default sizes for the shift sequencer and its step unit.
package shift_pkg;

    // Default operand width and step-count width.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    // Operation encoding as presented on Mode / {SelectB, SelectA}.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage : shift_pkg

// File: rtl/shift_seq_unit.sv
// Combinational single-bit step: rotate left/right through carry, pass or clear.
// Taken together, LHSIn and CarryIn form a (WIDTH+1)-bit value.
// SelectA is the low bit and SelectB the high bit of the operation code.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] LHSIn,
    input  logic             CarryIn,
    input  logic             SelectA,
    input  logic             SelectB,
    output logic [WIDTH-1:0] LHSOut,
    output logic             CarryOut
);

    mode_e w_op;

    assign w_op = mode_e'({SelectB, SelectA});

    // One step of the selected operation; the carry bit enters at the vacated end.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        LHSOut   = LHSIn;
        CarryOut = CarryIn;
        case (w_op)
            MODE_PASS: begin
                LHSOut   = LHSIn;
                CarryOut = CarryIn;
            end
            MODE_LEFT: begin
                LHSOut   = {LHSIn[WIDTH-2:0], CarryIn};
                CarryOut = LHSIn[WIDTH-1];
            end
            MODE_RIGHT: begin
                LHSOut   = {CarryIn, LHSIn[WIDTH-1:1]};
                CarryOut = LHSIn[0];
            end
            MODE_CLEAR: begin
                LHSOut   = '0;
                CarryOut = 1'b0;
            end
        endcase
    end

endmodule : shift_seq_unit

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer. An accepted request loads the operand, carry,
// step count and mode. The sequencer then applies one step per cycle until
// the count reaches zero. Done pulses for one cycle, then the block returns
// to IDLE. Results stay on LHSOut/CarryOut until the next accepted request.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic [CNT_W-1:0] Count,
    input  logic [WIDTH-1:0] LHSIn,
    input  logic             CarryIn,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] LHSOut,
    output logic             CarryOut
);

    // Sequencer state.
    state_e           r_state;
    state_e           w_state_nxt;

    // Operation registers: data D, carry C, remaining steps N, latched mode.
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    mode_e            r_mode;

    // Step unit interface.
    logic [1:0]       w_mode_bits;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_carry;

    // Control decode.
    logic             w_accept;
    logic             w_step;
    logic             w_ready;
    logic             w_done;

    assign w_mode_bits = r_mode;
    assign w_accept    = Start && (r_state == ST_IDLE);
    assign w_step      = (r_state == ST_SHIFT) && (r_count != '0);

    // The single-bit step, driven from the held registers.
    shift_seq_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .LHSIn    (r_data),
        .CarryIn  (r_carry),
        .SelectA  (w_mode_bits[0]),
        .SelectB  (w_mode_bits[1]),
        .LHSOut   (w_step_data),
        .CarryOut (w_step_carry)
    );

    // State register; reset forces IDLE so Ready rises as soon as reset asserts.
    always_ff @(posedge Clock or negedge ResetN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore outputs: Ready only in IDLE, Done only in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (Start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The N==0 edge leaves SHIFT without stepping.
                if (r_count == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, step while counting; otherwise hold the result.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_data  <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_mode  <= MODE_PASS;
        end else if (w_accept) begin
            r_data  <= LHSIn;
            r_carry <= CarryIn;
            r_count <= Count;
            r_mode  <= mode_e'(Mode);
        end else if (w_step) begin
            r_data  <= w_step_data;
            r_carry <= w_step_carry;
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign Ready    = w_ready;
    assign Done     = w_done;
    assign LHSOut   = r_data;
    assign CarryOut = r_carry;

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: rotations, zero count, clear/pass,
// busy-time Start and mid-operation reset.
module tb_shift_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             Clock = 1'b0;
    logic             ResetN;
    logic             Start;
    logic [1:0]       Mode;
    logic [CNT_W-1:0] Count;
    logic [WIDTH-1:0] LHSIn;
    logic             CarryIn;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] LHSOut;
    logic             CarryOut;

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .Start    (Start),
        .Mode     (Mode),
        .Count    (Count),
        .LHSIn    (LHSIn),
        .CarryIn  (CarryIn),
        .Ready    (Ready),
        .Done     (Done),
        .LHSOut   (LHSOut),
        .CarryOut (CarryOut)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of edges after the current point until Done is seen,
    // or limit+1 if it never appears.
    task automatic wait_done(input int limit, output int lat);
        lat = limit + 1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge Clock);
            #1;
            if (Done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    // Counts Done pulses over a window of edges.
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge Clock);
            #1;
            if (Done === 1'b1) pulses++;
        end
    endtask

    // Presents a request across one edge, then scrambles the inputs.
    task automatic start_op(input logic [1:0] m, input logic [CNT_W-1:0] n,
                            input logic [WIDTH-1:0] d, input logic c);
        @(negedge Clock);
        Mode    = m;
        Count   = n;
        LHSIn   = d;
        CarryIn = c;
        Start   = 1'b1;
        @(posedge Clock);
        #1;
        Start   = 1'b0;
        Mode    = ~m;
        Count   = ~n;
        LHSIn   = ~d;
        CarryIn = ~c;
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [CNT_W-1:0] n,
                          input logic [WIDTH-1:0] d, input logic c,
                          input int exp_lat, input logic [WIDTH-1:0] exp_d, input logic exp_c);
        int lat;
        start_op(m, n, d, c);
        check({tag, "_busy_ready"}, 32'(Ready), 32'(1'b0));
        wait_done(20, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_lhs"}, 32'(LHSOut), 32'(exp_d));
        check({tag, "_carry"}, 32'(CarryOut), 32'(exp_c));
        @(posedge Clock);
        #1;
        check({tag, "_done_len"}, 32'(Done), 32'(1'b0));
        check({tag, "_ready_back"}, 32'(Ready), 32'(1'b1));
        check({tag, "_lhs_hold"}, 32'(LHSOut), 32'(exp_d));
        check({tag, "_carry_hold"}, 32'(CarryOut), 32'(exp_c));
    endtask

    initial begin
        int lat;
        int pulses;

        ResetN  = 1'b0;
        Start   = 1'b0;
        Mode    = 2'b01;
        Count   = 3'd5;
        LHSIn   = 8'hFF;
        CarryIn = 1'b1;

        // Reset state, with clocks running.
        repeat (3) @(posedge Clock);
        #1;
        check("rst_ready", 32'(Ready), 32'(1'b1));
        check("rst_done", 32'(Done), 32'(1'b0));
        check("rst_lhs", 32'(LHSOut), 32'h00);
        check("rst_carry", 32'(CarryOut), 32'(1'b0));
        @(negedge Clock);
        ResetN = 1'b1;

        // Left rotate through carry: 81,C=1 -> 03,1 -> 07,0 -> 0E,0.
        run_op("left3", 2'b01, 3'd3, 8'h81, 1'b1, 4, 8'h0E, 1'b0);
        // Right rotate: 01,C=0 -> 00,1 -> 80,0.
        run_op("right2", 2'b10, 3'd2, 8'h01, 1'b0, 3, 8'h80, 1'b0);
        // Zero count returns the operand untouched.
        run_op("zero_left", 2'b01, 3'd0, 8'hA5, 1'b1, 1, 8'hA5, 1'b1);
        // Clear with one step.
        run_op("clear1", 2'b11, 3'd1, 8'hFF, 1'b1, 2, 8'h00, 1'b0);
        // Pass with maximum count.
        run_op("pass7", 2'b00, 3'd7, 8'h3C, 1'b1, 8, 8'h3C, 1'b1);
        // Zero count in clear mode still returns the operand.
        run_op("zero_clear", 2'b11, 3'd0, 8'h5A, 1'b1, 1, 8'h5A, 1'b1);

        // Busy: 96,C=0 left x5 -> 2C,1 -> 59,0 -> B2,0 -> 64,1 -> C9,0.
        start_op(2'b01, 3'd5, 8'h96, 1'b0);
        @(negedge Clock);
        Start   = 1'b1;
        Mode    = 2'b11;
        Count   = 3'd1;
        LHSIn   = 8'h00;
        CarryIn = 1'b0;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("busy_no_done_early", 32'(Done), 32'(1'b0));
        wait_done(20, lat);
        check("busy_latency", 32'(lat), 32'd5);
        check("busy_lhs", 32'(LHSOut), 32'hC9);
        check("busy_carry", 32'(CarryOut), 32'(1'b0));
        // Start raised while in DONE must not be taken either.
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("busy_done_start_ready", 32'(Ready), 32'(1'b1));
        check("busy_result_hold", 32'(LHSOut), 32'hC9);
        count_done(12, pulses);
        check("busy_single_done", 32'(pulses), 32'd0);

        // Abort: reset during SHIFT.
        start_op(2'b10, 3'd6, 8'hF0, 1'b1);
        repeat (2) @(posedge Clock);
        #1;
        ResetN = 1'b0;
        #1;
        check("abort_ready", 32'(Ready), 32'(1'b1));
        check("abort_done", 32'(Done), 32'(1'b0));
        check("abort_lhs", 32'(LHSOut), 32'h00);
        check("abort_carry", 32'(CarryOut), 32'(1'b0));
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        count_done(12, pulses);
        check("abort_no_done", 32'(pulses), 32'd0);

        // Fresh operation after the abort: 02,C=1 right x1 -> 81,0.
        run_op("post_abort", 2'b10, 3'd1, 8'h02, 1'b1, 2, 8'h81, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_seq

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter CNT_W, default 3, width of the Count port; maximum shift count is 2**CNT_W-1.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request a shift; accepted only at a rising edge where Ready=1.
REQ-006 Mode  input  2  operation: 00 pass, 01 shift left, 10 shift right, 11 clear.
REQ-007 Count  input  CNT_W  number of single-bit steps to perform.
REQ-008 LHSIn  input  WIDTH  operand.
REQ-009 CarryIn  input  1  initial carry.
REQ-010 Ready  output  1  high only in IDLE.
REQ-011 Done  output  1  one-cycle pulse marking valid results.
REQ-012 LHSOut  output  WIDTH  result register.
REQ-013 CarryOut  output  1  carry result register.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 On acceptance in IDLE, the block SHALL capture Mode, Count, LHSIn and CarryIn into the data register D, carry register C, step counter N and mode register, then enter SHIFT.
REQ-016 In SHIFT, each edge with N!=0 SHALL perform one step and decrement N; the edge with N==0 SHALL enter DONE without stepping.
REQ-017 Step rules, with C as carry-in:
- left: D<={D[W-2:0],C}, C<=D[W-1]
- right: D<={C,D[W-1:1]}, C<=D[0]
- pass: D and C unchanged
- clear: D<=0, C<=0
REQ-018 Steps therefore SHALL form a (WIDTH+1)-bit rotate through carry.
REQ-019 In DONE, Done SHALL be 1 for exactly one cycle and the next edge SHALL return the FSM to IDLE.
REQ-020 Done SHALL be asserted Count+1 cycles after the accepting edge; throughput is one operation per Count+3 cycles.
REQ-021 LHSOut and CarryOut SHALL be driven directly from D and C.
REQ-022 Final results SHALL hold stable from DONE until the next accepting edge.
REQ-023 Intermediate values of LHSOut and CarryOut during SHIFT are don't-care for consumers.
REQ-024 Count=0 SHALL return LHSIn and CarryIn unchanged in every mode, including clear.
REQ-025 Start while Ready=0 (SHIFT or DONE) SHALL be ignored and not queued.
REQ-026 Input changes after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-027 While ResetN=0, the state SHALL be IDLE and outputs SHALL be Ready=1, Done=0, LHSOut=0, CarryOut=0, with N=0.
REQ-028 Reset mid-operation SHALL abort without a Done pulse; the first accepting edge after release starts a fresh operation.

Structure
REQ-029 Package shift_pkg SHALL hold the Mode encoding enum, the FSM state typedef and the default WIDTH/CNT_W constants.
REQ-030 The single-bit step SHALL be an instance of the existing combinational shift unit:
- Mode[0] drives SelectA and Mode[1] drives SelectB.
- D drives LHSIn and C drives CarryIn.
- LHSOut/CarryOut feed D/C when stepping.
REQ-031 No other sub-modules.

Verification
REQ-032 Reset: ResetN=0 during any state -> Ready=1, Done=0, LHSOut=00, CarryOut=0 immediately (asynchronous).
REQ-033 Left rotate: Mode=01, Count=3, LHSIn=81, CarryIn=1 -> Done 4 cycles after accept, LHSOut=0E, CarryOut=0.
REQ-034 Right rotate: Mode=10, Count=2, LHSIn=01, CarryIn=0 -> Done 3 cycles after accept, LHSOut=80, CarryOut=0.
REQ-035 Zero count: Mode=01, Count=0, LHSIn=A5, CarryIn=1 -> Done 1 cycle after accept, LHSOut=A5, CarryOut=1.
REQ-036 Clear and pass:
- Mode=11, Count=1, LHSIn=FF, CarryIn=1 -> LHSOut=00, CarryOut=0.
- Mode=00, Count=7, LHSIn=3C, CarryIn=1 -> LHSOut=3C, CarryOut=1, Done 8 cycles after accept.
REQ-037 Busy and abort:
- Start pulsed during SHIFT -> ignored; exactly one Done with the original result.
- ResetN low mid-SHIFT -> no Done, outputs 0, Ready=1.
